// File: rtl/regs_pkg.sv
// Shared register-index types and constants for the issue-stage scoreboard.
// The one-hot decode helper is shared by the top and the bench-facing interface.
package regs_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t          XZR     = 5'd31;
    localparam logic [NREG-1:0]   XZR_BIT = 32'd1 << XZR;

    function automatic logic [NREG-1:0] reg_dec(input reg_idx_t idx);
        reg_dec      = '0;
        reg_dec[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status signals of the register scoreboard.
// master drives decode/writeback inputs; slave is the scoreboard itself.
interface reg_scoreboard_if
    import regs_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic                 issue_valid;
    reg_idx_t             rs1;
    logic                 rs1_used;
    reg_idx_t             rs2;
    logic                 rs2_used;
    reg_idx_t             rd;
    logic                 rd_wr;
    logic                 wb_valid;
    reg_idx_t             wb_rd;
    logic                 flush;
    logic                 stall;
    logic                 issue_ack;
    logic [NREG-1:0]      busy_vec;
    logic [5:0]           pending_cnt;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output issue_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_wr,
        output wb_valid, wb_rd, flush,
        input  stall, issue_ack, busy_vec, pending_cnt, stall_cycles
    );

    modport slave (
        input  issue_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_wr,
        input  wb_valid, wb_rd, flush,
        output stall, issue_ack, busy_vec, pending_cnt, stall_cycles
    );
endinterface

// File: rtl/reg_scoreboard_mux.sv
// 32:1 one-bit mux over the register file, selected by a 5-bit register index.
// Latency: combinational; no backpressure.
module reg_scoreboard_mux
    import regs_pkg::*;
(
    input  logic [NREG-1:0] data,
    input  reg_idx_t        sel,
    output logic            bit_out
);
    assign bit_out = data[sel];
endmodule

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard at issue: stalls RAW/WAW hazards, clears on writeback.
// Latency: stall/issue_ack combinational, state one cycle; stall is the backpressure to decode.
module reg_scoreboard
    import regs_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)(
    input  logic           clk,
    input  logic           reset,
    reg_scoreboard_if.slave sb
);
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [NREG-1:0]      clr_vec;
    logic [NREG-1:0]      set_vec;
    logic [NREG-1:0]      lookup_vec;
    logic [5:0]           cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 eb_rs1;
    logic                 eb_rs2;
    logic                 eb_rd;
    logic                 stall_w;
    logic                 ack_w;
    logic                 cnt_inc;
    logic                 cnt_dec;

    assign clr_vec = sb.wb_valid ? reg_dec(sb.wb_rd) : '0;

    // A writeback landing this cycle already satisfies the hazard.
    assign lookup_vec = busy_q & ~clr_vec & ~XZR_BIT;

    reg_scoreboard_mux u_mux_rs1 (.data(lookup_vec), .sel(sb.rs1), .bit_out(eb_rs1));
    reg_scoreboard_mux u_mux_rs2 (.data(lookup_vec), .sel(sb.rs2), .bit_out(eb_rs2));
    reg_scoreboard_mux u_mux_rd  (.data(lookup_vec), .sel(sb.rd),  .bit_out(eb_rd));

    assign stall_w = sb.issue_valid & ((sb.rs1_used & eb_rs1) |
                                       (sb.rs2_used & eb_rs2) |
                                       (sb.rd_wr    & eb_rd));
    assign ack_w   = sb.issue_valid & ~stall_w;

    assign set_vec = (ack_w & sb.rd_wr) ? (reg_dec(sb.rd) & ~XZR_BIT) : '0;

    // Set takes priority over a clear of the same register in one cycle.
    assign busy_d  = sb.flush ? '0 : ((busy_q | set_vec) & ~(clr_vec & ~set_vec));

    assign cnt_inc = |(set_vec & ~busy_q);
    assign cnt_dec = |(clr_vec & busy_q & ~set_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (sb.flush) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
            end
            if (stall_w && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign sb.stall        = stall_w;
    assign sb.issue_ack    = ack_w;
    assign sb.busy_vec     = busy_q;
    assign sb.pending_cnt  = cnt_q;
    assign sb.stall_cycles = stall_cnt_q;

endmodule
